mem_access_unit: RTL and testbench

Multicycle memory port between the control unit and the single unified memory. It turns the control unit's one-cycle access strobes (IorD, MemRead, MemWrite, IRWrite) into a registered read/write handshake with a variable-latency memory. It latches fetched words into the instruction register (IR), which drives the control unit's `inst`, and latches load data into the memory data register (MDR). While an access is outstanding it holds `busy` so the control unit can stall its state machine.

---
 rtl/mem_access_unit_pkg.sv | 20 ++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_wrap_counter.sv | 26 ++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the multicycle memory access unit: word width,
// FSM state encodings and the address-select helper.
package mem_access_unit_pkg;

  localparam int WORD_SIZE = 16;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_BUSY = 2'd1,
    MAU_DONE = 2'd2
  } mau_state_t;

  // iord=0 selects the instruction address, iord=1 the data address.
  function automatic word_t select_addr(input logic iord, input word_t pc, input word_t alu_addr);
    return iord ? alu_addr : pc;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Handshake bus between the access unit (master) and the unified
// variable-latency memory (slave).
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic  m_read;
  logic  m_write;
  word_t m_address;
  word_t m_wdata;
  word_t m_rdata;
  logic  m_ready;

  modport master (
    output m_read, m_write, m_address, m_wdata,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_read, m_write, m_address, m_wdata,
    output m_rdata, m_ready
  );

endinterface

// File: rtl/mem_access_unit_wrap_counter.sv
// Free-running enable counter that wraps silently at all-ones.
module wrap_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  assign count_next = en ? count_reg + 1'b1 : count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle memory port: turns control-unit access strobes into a registered
// read/write handshake and latches fetched words into IR and loads into MDR.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_read,
  input  logic                req_write,
  input  logic                iord,
  input  logic                ir_write,
  input  word_t               pc,
  input  word_t               alu_addr,
  input  word_t               wdata,
  output word_t               inst,
  output word_t               mdr,
  output logic                busy,
  output logic                done,
  output logic                err,
  output word_t               fetch_count,
  output word_t               data_count,
  mem_access_unit_if.master   mem
);

  mau_state_t state_reg;
  logic       iord_reg;
  logic       ir_write_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       err_reg;
  logic       m_read_reg;
  logic       m_write_reg;
  word_t      m_address_reg;
  word_t      m_wdata_reg;
  word_t      inst_reg;
  word_t      mdr_reg;

  logic       complete;
  logic       fetch_inc;
  logic       data_inc;

  assign complete  = (state_reg == MAU_BUSY) && mem.m_ready;
  assign fetch_inc = complete && !iord_reg;
  assign data_inc  = complete && iord_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= MAU_IDLE;
      iord_reg      <= 1'b0;
      ir_write_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      m_read_reg    <= 1'b0;
      m_write_reg   <= 1'b0;
      m_address_reg <= '0;
      m_wdata_reg   <= '0;
      inst_reg      <= '0;
      mdr_reg       <= '0;
    end else begin
      case (state_reg)
        MAU_IDLE: begin
          if (req_read ^ req_write) begin
            iord_reg      <= iord;
            ir_write_reg  <= ir_write;
            m_address_reg <= select_addr(iord, pc, alu_addr);
            m_wdata_reg   <= wdata;
            m_read_reg    <= req_read;
            m_write_reg   <= req_write;
            busy_reg      <= 1'b1;
            state_reg     <= MAU_BUSY;
          end else if (req_read && req_write) begin
            err_reg <= 1'b1;
          end
        end
        MAU_BUSY: begin
          if (mem.m_ready) begin
            // Only reads update IR/MDR; fetches without ir_write discard the word.
            if (m_read_reg) begin
              if (iord_reg) begin
                mdr_reg <= mem.m_rdata;
              end else if (ir_write_reg) begin
                inst_reg <= mem.m_rdata;
              end
            end
            m_read_reg  <= 1'b0;
            m_write_reg <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= MAU_DONE;
          end
        end
        MAU_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= MAU_IDLE;
        end
        default: begin
          done_reg    <= 1'b0;
          busy_reg    <= 1'b0;
          m_read_reg  <= 1'b0;
          m_write_reg <= 1'b0;
          state_reg   <= MAU_IDLE;
        end
      endcase
    end
  end

  wrap_counter #(.WIDTH(WORD_SIZE)) u_fetch_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (fetch_inc),
    .count   (fetch_count)
  );

  wrap_counter #(.WIDTH(WORD_SIZE)) u_data_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (data_inc),
    .count   (data_count)
  );

  assign inst          = inst_reg;
  assign mdr           = mdr_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign err           = err_reg;
  assign mem.m_read    = m_read_reg;
  assign mem.m_write   = m_write_reg;
  assign mem.m_address = m_address_reg;
  assign mem.m_wdata   = m_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected completions are queued at issue
// time and a negedge monitor checks them whenever done is presented.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct {
    word_t inst;
    word_t mdr;
    word_t fc;
    word_t dc;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset_n;
  logic  req_read, req_write, iord, ir_write;
  word_t pc, alu_addr, wdata;
  word_t inst, mdr, fetch_count, data_count;
  logic  busy, done, err;

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];

  mem_access_unit_if mem_bus();

  mem_access_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_read    (req_read),
    .req_write   (req_write),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc          (pc),
    .alu_addr    (alu_addr),
    .wdata       (wdata),
    .inst        (inst),
    .mdr         (mdr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .fetch_count (fetch_count),
    .data_count  (data_count),
    .mem         (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_inst", inst, e.inst);
        check("done_mdr", mdr, e.mdr);
        check("done_fetch_count", fetch_count, e.fc);
        check("done_data_count", data_count, e.dc);
        check("done_m_read_low", {15'd0, mem_bus.m_read}, 16'd0);
        check("done_m_write_low", {15'd0, mem_bus.m_write}, 16'd0);
      end
    end
  end

  // Issue one access from IDLE at a negedge; m_ready arrives in BUSY cycle k.
  task automatic do_access(input logic rd, input logic wr, input logic io, input logic irw,
                           input word_t pc_i, input word_t alu_i, input word_t wd_i,
                           input word_t rdata_i, input int k,
                           input word_t e_inst, input word_t e_mdr,
                           input word_t e_fc, input word_t e_dc,
                           input bit strobe_busy, input bit strobe_done);
    exp_t  e;
    word_t exp_addr;
    exp_addr = io ? alu_i : pc_i;
    e.inst = e_inst; e.mdr = e_mdr; e.fc = e_fc; e.dc = e_dc;
    exp_q.push_back(e);
    req_read = rd; req_write = wr; iord = io; ir_write = irw;
    pc = pc_i; alu_addr = alu_i; wdata = wd_i;
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b0;
    pc = ~pc_i; alu_addr = ~alu_i; wdata = ~wd_i; iord = ~io;
    check("busy_c1", {15'd0, busy}, 16'd1);
    check("m_read_c1", {15'd0, mem_bus.m_read}, {15'd0, rd});
    check("m_write_c1", {15'd0, mem_bus.m_write}, {15'd0, wr});
    check("m_wdata_c1", mem_bus.m_wdata, wd_i);
    for (int i = 1; i <= k; i++) begin
      check("m_address_hold", mem_bus.m_address, exp_addr);
      if (strobe_busy && i == 1) req_read = 1'b1;
      if (i == k) begin
        mem_bus.m_ready = 1'b1;
        mem_bus.m_rdata = rdata_i;
      end
      @(negedge clk);
      req_read = 1'b0;
      mem_bus.m_ready = 1'b0;
      mem_bus.m_rdata = 16'h0BAD;
    end
    check("done_cycle", {15'd0, done}, 16'd1);
    check("busy_in_done", {15'd0, busy}, 16'd1);
    if (strobe_done) req_write = 1'b1;
    @(negedge clk);
    req_write = 1'b0;
    check("idle_busy", {15'd0, busy}, 16'd0);
    check("idle_done", {15'd0, done}, 16'd0);
    @(negedge clk);
    check("idle_stays", {15'd0, busy | mem_bus.m_read | mem_bus.m_write}, 16'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_read = 1'b1; req_write = 1'b1; iord = 1'b1; ir_write = 1'b1;
    pc = 16'hDEAD; alu_addr = 16'hCAFE; wdata = 16'h5A5A;
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 16'h7777;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    // Garbage with both strobes set: err rises, nothing issued.
    check("garbage_err", {15'd0, err}, 16'd1);
    check("garbage_no_read", {15'd0, mem_bus.m_read}, 16'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_inst", inst, 16'h0000);
    check("rst_mdr", mdr, 16'h0000);
    check("rst_flags", {13'd0, busy, done, err}, 16'd0);
    check("rst_fetch_count", fetch_count, 16'h0000);
    check("rst_data_count", data_count, 16'h0000);
    check("rst_m_rw", {14'd0, mem_bus.m_read, mem_bus.m_write}, 16'd0);
    check("rst_m_address", mem_bus.m_address, 16'h0000);
    check("rst_m_wdata", mem_bus.m_wdata, 16'h0000);
    req_read = 1'b0; req_write = 1'b0; iord = 1'b0; ir_write = 1'b0;
    pc = '0; alu_addr = '0; wdata = '0;
    mem_bus.m_ready = 1'b0; mem_bus.m_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Instruction fetch, m_ready in 3rd BUSY cycle.
    do_access(1, 0, 0, 1, 16'h0040, 16'h1111, 16'h0000, 16'hF01C, 3,
              16'hF01C, 16'h0000, 16'd1, 16'd0, 0, 0);
    // Load with immediate m_ready.
    do_access(1, 0, 1, 0, 16'h0042, 16'h0100, 16'h0000, 16'h1234, 1,
              16'hF01C, 16'h1234, 16'd1, 16'd1, 0, 0);
    // Store: read data on the bus must not reach MDR.
    do_access(0, 1, 1, 1, 16'h0044, 16'h0101, 16'hBEEF, 16'h5555, 2,
              16'hF01C, 16'h1234, 16'd1, 16'd2, 0, 0);
    // Fetch without ir_write: word discarded, still counted.
    do_access(1, 0, 0, 0, 16'h0044, 16'h0000, 16'h0000, 16'hAAAA, 1,
              16'hF01C, 16'h1234, 16'd2, 16'd2, 0, 0);
    // Strobes during BUSY and DONE are ignored.
    do_access(1, 0, 0, 1, 16'h0046, 16'h0000, 16'h0000, 16'h1111, 3,
              16'h1111, 16'h1234, 16'd3, 16'd2, 1, 1);

    // m_ready while IDLE has no effect.
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 16'h9999;
    @(negedge clk);
    mem_bus.m_ready = 1'b0;
    @(negedge clk);
    check("idle_ready_busy", {15'd0, busy}, 16'd0);
    check("idle_ready_inst", inst, 16'h1111);
    check("idle_ready_mdr", mdr, 16'h1234);
    check("idle_ready_fc", fetch_count, 16'd3);

    // Both strobes in IDLE: error, no bus activity.
    req_read = 1'b1; req_write = 1'b1;
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b0;
    check("illegal_err", {15'd0, err}, 16'd1);
    check("illegal_no_rw", {14'd0, mem_bus.m_read, mem_bus.m_write}, 16'd0);
    check("illegal_busy", {15'd0, busy}, 16'd0);
    do_access(1, 0, 1, 0, 16'h0048, 16'h0200, 16'h0000, 16'h0077, 2,
              16'h1111, 16'h0077, 16'd3, 16'd3, 0, 0);
    check("err_sticky", {15'd0, err}, 16'd1);

    // Preload the fetch counter to all-ones, then one more fetch wraps it.
    force dut.u_fetch_counter.count_next = 16'hFFFF;
    @(negedge clk);
    release dut.u_fetch_counter.count_next;
    @(negedge clk);
    check("preload_fc", fetch_count, 16'hFFFF);
    do_access(1, 0, 0, 1, 16'h0048, 16'h0000, 16'h0000, 16'h2222, 1,
              16'h2222, 16'h0077, 16'd0, 16'd3, 0, 0);

    // Reset in the 2nd BUSY cycle: abandoned, no done, IR back to 0.
    req_read = 1'b1; iord = 1'b0; ir_write = 1'b1; pc = 16'h004A;
    @(negedge clk);
    req_read = 1'b0;
    @(negedge clk);
    check("midacc_m_read", {15'd0, mem_bus.m_read}, 16'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midacc_m_read_drop", {15'd0, mem_bus.m_read}, 16'd0);
    check("midacc_busy", {15'd0, busy}, 16'd0);
    check("midacc_inst", inst, 16'h0000);
    check("midacc_err", {15'd0, err}, 16'd0);
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 16'h3333;
    repeat (2) @(negedge clk);
    mem_bus.m_ready = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_inst", inst, 16'h0000);
    check("post_rst_fc", fetch_count, 16'h0000);
    check("post_rst_busy", {15'd0, busy}, 16'd0);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_done actual=%0d required=0 pending", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
